// File: rtl/saus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saus_pkg : shared types and row-size helpers for the SAUS input path     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package saus_pkg;
   localparam int         SAMPLE_WIDTH = 16;
   localparam int         MAX_N        = 32;
   localparam int         LOG2_MAX_N   = 5;
   localparam logic [2:0] LOG2N_MIN    = 3'd2;
   localparam logic [2:0] LOG2N_MAX    = 3'd5;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
   typedef sample_t [MAX_N-1:0]            row_t;

   // N = MAX_N >> depth
   function automatic logic [2:0] depth_of(input logic [2:0] log2n);
      return 3'(LOG2_MAX_N) - log2n;
   endfunction

   function automatic logic log2n_legal(input logic [2:0] log2n);
      return (log2n >= LOG2N_MIN) && (log2n <= LOG2N_MAX);
   endfunction

   function automatic logic [2:0] clamp_log2n(input logic [2:0] log2n);
      if (log2n < LOG2N_MIN) return LOG2N_MIN;
      if (log2n > LOG2N_MAX) return LOG2N_MAX;
      return log2n;
   endfunction
endpackage
`default_nettype wire

// File: rtl/saus_row_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saus_row_bank : one 32-entry row buffer with clear-on-first-beat writes  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module saus_row_bank
   import saus_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANES = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_wr_en,
   input  logic                            i_first,
   input  logic                            i_last,
   input  logic [4:0]                      i_base,
   input  logic [LANES-1:0][WIDTH-1:0]     i_data,
   input  logic [2:0]                      i_log2n,
   input  logic                            i_pop,
   output logic                            o_full,
   output logic [2:0]                      o_log2n,
   output logic [MAX_N-1:0][WIDTH-1:0]     o_vector
);
   logic                        r_full;
   logic [2:0]                  r_log2n;
   logic [MAX_N-1:0][WIDTH-1:0] r_vec;

   // Writes only happen while empty and pops only while full, so they never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full  <= 1'b0;
         r_log2n <= LOG2N_MAX;
         r_vec   <= '0;
      end else if (i_wr_en) begin
         if (i_first) begin
            r_log2n <= i_log2n;
            r_vec   <= '0;
         end
         for (int k = 0; k < LANES; k++) begin
            r_vec[i_base + 5'(k)] <= i_data[k];
         end
         if (i_last) begin
            r_full <= 1'b1;
         end
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   assign o_full   = r_full;
   assign o_log2n  = r_log2n;
   assign o_vector = r_vec;
endmodule
`default_nettype wire

// File: rtl/saus_row_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saus_row_loader : ping-pong row collector feeding the back-permutation   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module saus_row_loader
   import saus_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANES = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_in_valid,
   output logic                            o_in_ready,
   input  logic [LANES-1:0][WIDTH-1:0]     i_in_data,
   input  logic [2:0]                      i_in_log2n,
   output logic                            o_out_valid,
   input  logic                            i_out_ready,
   output logic [MAX_N-1:0][WIDTH-1:0]     o_out_vector,
   output logic [2:0]                      o_out_depth,
   output logic                            o_err_size
);
   localparam int LOG2_LANES = $clog2(LANES);

   logic                        r_wr_ptr;
   logic                        r_rd_ptr;
   logic [4:0]                  r_beat_cnt;
   logic                        r_err_size;

   logic                        w_full  [2];
   logic [2:0]                  w_log2n [2];
   logic [MAX_N-1:0][WIDTH-1:0] w_vec   [2];

   logic       w_in_ready;
   logic       w_accept;
   logic       w_first;
   logic       w_last;
   logic       w_pop;
   logic [2:0] w_log2n_in;
   logic [2:0] w_row_log2n;
   logic [4:0] w_last_cnt;
   logic [4:0] w_base;

   assign w_in_ready  = !w_full[r_wr_ptr] && !rst;
   assign w_accept    = i_in_valid && w_in_ready;
   assign w_first     = (r_beat_cnt == 5'd0);
   assign w_log2n_in  = clamp_log2n(i_in_log2n);
   // The row length is taken from the input only on beat 0, from the bank afterwards.
   assign w_row_log2n = w_first ? w_log2n_in : w_log2n[r_wr_ptr];
   assign w_last_cnt  = 5'((32'd1 << (w_row_log2n - 3'(LOG2_LANES))) - 32'd1);
   assign w_last      = (r_beat_cnt == w_last_cnt);
   assign w_base      = r_beat_cnt << LOG2_LANES;
   assign w_pop       = w_full[r_rd_ptr] && i_out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_beat_cnt <= 5'd0;
         r_err_size <= 1'b0;
      end else begin
         r_err_size <= w_accept && w_first && !log2n_legal(i_in_log2n);
         if (w_accept) begin
            if (w_last) begin
               r_beat_cnt <= 5'd0;
               r_wr_ptr   <= ~r_wr_ptr;
            end else begin
               r_beat_cnt <= r_beat_cnt + 5'd1;
            end
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      saus_row_bank #(
         .WIDTH (WIDTH),
         .LANES (LANES)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .i_wr_en  (w_accept && (r_wr_ptr == 1'(b))),
         .i_first  (w_first),
         .i_last   (w_last),
         .i_base   (w_base),
         .i_data   (i_in_data),
         .i_log2n  (w_log2n_in),
         .i_pop    (w_pop && (r_rd_ptr == 1'(b))),
         .o_full   (w_full[b]),
         .o_log2n  (w_log2n[b]),
         .o_vector (w_vec[b])
      );
   end

   assign o_in_ready   = w_in_ready;
   assign o_out_valid  = w_full[r_rd_ptr];
   assign o_out_vector = w_vec[r_rd_ptr];
   assign o_out_depth  = depth_of(w_log2n[r_rd_ptr]);
   assign o_err_size   = r_err_size;
endmodule
`default_nettype wire

// File: tb/tb_saus_row_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_saus_row_loader : scoreboard bench for the SAUS row loader            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_saus_row_loader;
   localparam int W = 16;
   localparam int L = 4;

   typedef logic [L-1:0][W-1:0] beat_t;
   typedef logic [31:0][W-1:0]  vec_t;
   typedef struct {
      vec_t       vec;
      logic [2:0] depth;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid;
   logic       in_ready;
   beat_t      in_data;
   logic [2:0] in_log2n;
   logic       out_valid;
   logic       out_ready;
   vec_t       out_vector;
   logic [2:0] out_depth;
   logic       err_size;

   exp_t exp_q[$];
   exp_t cur;
   int   checks     = 0;
   int   failures   = 0;
   int   err_pulses = 0;

   saus_row_loader #(.WIDTH(W), .LANES(L)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .i_in_data    (in_data),
      .i_in_log2n   (in_log2n),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_out_vector (out_vector),
      .o_out_depth  (out_depth),
      .o_err_size   (err_size)
   );

   always #5 clk = ~clk;

   // Monitor: every output handshake is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (err_size) err_pulses++;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_row actual=row depth %0d required=no row", out_depth);
         end else begin
            cur = exp_q.pop_front();
            if (out_vector !== cur.vec) begin
               failures++;
               $display("FAIL row_vector actual=%h required=%h", out_vector, cur.vec);
            end
            checks++;
            if (out_depth !== cur.depth) begin
               failures++;
               $display("FAIL row_depth actual=%0d required=%0d", out_depth, cur.depth);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic beat_t mk(input int a, input int b, input int c, input int d);
      beat_t r;
      r[0] = 16'(a);
      r[1] = 16'(b);
      r[2] = 16'(c);
      r[3] = 16'(d);
      return r;
   endfunction

   task automatic beat(input beat_t d, input logic [2:0] l2, output int waited);
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_log2n = l2;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=in_ready 0 required=1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Row of n samples start, start+1, ...; expected depth given by the caller.
   task automatic row_seq(input int start, input int n, input logic [2:0] l2,
                          input logic [2:0] depth, output int waits);
      exp_t e;
      int   w;
      e.vec   = '0;
      e.depth = depth;
      for (int i = 0; i < n; i++) e.vec[i] = 16'(start + i);
      exp_q.push_back(e);
      waits = 0;
      for (int b = 0; b < n / L; b++) begin
         beat(mk(start + 4*b, start + 4*b + 1, start + 4*b + 2, start + 4*b + 3), l2, w);
         waits += w;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((out_valid || exp_q.size() != 0) && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int   w1, w2, w;
      exp_t e;
      in_valid  = 1'b0;
      in_data   = '0;
      in_log2n  = 3'd5;
      out_ready = 1'b1;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_vector_zero", 64'(|out_vector), 0);
      chk("rst_depth", out_depth, 0);
      chk("rst_err_size", err_size, 0);
      rst = 1'b0;
      #1;
      chk("release_in_ready", in_ready, 1);

      // N=32, samples 0..31
      row_seq(0, 32, 3'd5, 3'd0, w);
      chk("n32_latency", out_valid, 1);
      drain();

      // N=8 with negative samples, zero padded above position 7
      e.vec   = '0;
      e.depth = 3'd2;
      e.vec[0] = 16'(-1); e.vec[1] = 16'(-2); e.vec[2] = 16'(-3); e.vec[3] = 16'(-4);
      e.vec[4] = 16'(5);  e.vec[5] = 16'(6);  e.vec[6] = 16'(7);  e.vec[7] = 16'(8);
      exp_q.push_back(e);
      beat(mk(-1, -2, -3, -4), 3'd3, w);
      beat(mk(5, 6, 7, 8), 3'd3, w);
      chk("n8_latency", out_valid, 1);
      drain();

      // Output stall: two N=4 rows fill both banks, third waits
      out_ready = 1'b0;
      row_seq(10, 4, 3'd2, 3'd3, w);
      row_seq(20, 4, 3'd2, 3'd3, w);
      chk("both_full_in_ready", in_ready, 0);
      chk("both_full_out_valid", out_valid, 1);
      e.vec   = '0;
      e.depth = 3'd3;
      for (int i = 0; i < 4; i++) e.vec[i] = 16'(30 + i);
      exp_q.push_back(e);
      in_valid = 1'b1;
      in_data  = mk(30, 31, 32, 33);
      in_log2n = 3'd2;
      repeat (3) @(posedge clk);
      #1;
      chk("stall_hold_in_ready", in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("after_pop_out_valid", out_valid, 1);
      chk("after_pop_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Mixed sizes back to back: N=4 then N=16
      row_seq(40, 4, 3'd2, 3'd3, w1);
      row_seq(50, 16, 3'd4, 3'd1, w2);
      chk("mixed_no_idle", 64'(w1 + w2), 64'd0);
      drain();

      // Illegal size on beat 0, later beats carry a different (ignored) size
      err_pulses = 0;
      e.vec   = '0;
      e.depth = 3'd0;
      for (int i = 0; i < 32; i++) e.vec[i] = 16'(60 + i);
      exp_q.push_back(e);
      beat(mk(60, 61, 62, 63), 3'd7, w);
      chk("err_size_pulse", err_size, 1);
      for (int b = 1; b < 8; b++) begin
         beat(mk(60 + 4*b, 61 + 4*b, 62 + 4*b, 63 + 4*b), 3'd0, w);
         if (b == 6) chk("illegal_not_early", out_valid, 0);
      end
      chk("illegal_latency", out_valid, 1);
      drain();
      chk("err_pulse_count", 64'(err_pulses), 64'd1);

      // Reset mid-row discards the partial row
      for (int b = 0; b < 3; b++) begin
         beat(mk(100 + 4*b, 101 + 4*b, 102 + 4*b, 103 + 4*b), 3'd5, w);
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrow_rst_out_valid", out_valid, 0);
      chk("midrow_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      row_seq(200, 32, 3'd5, 3'd0, w);
      chk("post_rst_latency", out_valid, 1);
      drain();

      repeat (5) @(posedge clk);
      #1;
      chk("final_no_output", out_valid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/saus_row_loader.md
# saus_row_loader

Input row loader for the SAUS input-selection path. Collects signed coefficient samples arriving `LANES` per beat into a 32-entry row vector, zero-pads positions beyond the row length, and presents the completed vector with its matching `DEPTH` code. Its consumer is the tangled-to-sorted back-permutation stage, which takes `out_vector` and `out_depth` directly. The loader is ping-pong buffered so that loading the next row overlaps any stall on the output side.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `LANES`, 4: samples per input beat; a power of two, 1..4.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: the input beat is valid.
- `in_ready` out 1: the loader accepts a beat this cycle.
- `in_data` in `[LANES-1:0]` x `WIDTH` signed: samples; lane k belongs at row position base+k.
- `in_log2n` in 3: log2 of row length N. Legal values are 2..5 (N = 4..32). Sampled on the first beat of a row only.
- `out_valid` out 1: a completed row is presented.
- `out_ready` in 1: the consumer takes the row.
- `out_vector` out `[31:0]` x `WIDTH` signed: the completed row. Positions at or above N are 0.
- `out_depth` out 3: 5 - log2n, so that N = 32 >> `out_depth`.
- `err_size` out 1: single-cycle pulse when the sampled `in_log2n` was illegal.

## Operation
- Two banks, 0 and 1. Each bank has a full flag, a latched log2n, and 32 sample registers.
- Pointers: `wr_ptr` selects the bank being filled; `rd_ptr` selects the bank being presented. Both reset to 0.
- `in_ready` = !full[wr_ptr] && !rst.
- Beat acceptance requires `in_valid` && `in_ready`.
- On the first beat of a row (beat count 0):
  - Latch log2n into the bank.
  - An illegal value is clamped: below 2 becomes 2, above 5 becomes 5. `err_size` pulses in the following cycle.
  - Clear all 32 positions of the bank to 0 in the same cycle the beat's lanes are written.
- Each beat writes lane k to position beat_cnt*LANES + k. Then beat_cnt increments.
- The row is complete on the beat where beat_cnt == N/LANES - 1. On that beat:
  - Set full[wr_ptr].
  - Toggle `wr_ptr`.
  - Reset beat_cnt to 0.
- `out_valid` = full[rd_ptr].
- `out_vector` and `out_depth` are driven from bank `rd_ptr`, and are stable while `out_valid` && !`out_ready`.
- On `out_valid` && `out_ready`: clear full[rd_ptr] and toggle `rd_ptr`.
- Arithmetic: samples are stored unmodified. No saturation and no sign manipulation.

## Timing
- Reset values:
  - `out_valid`=0, `err_size`=0.
  - `out_vector` all 0, `out_depth`=0.
  - Both full flags 0, beat_cnt 0.
  - `in_ready`=0 while `rst` is high, and 1 in the first cycle after release.
- Latency: the last beat is accepted at edge t, and `out_valid`=1 in the cycle following t.
- Throughput: one beat per cycle sustained when `out_ready` is held high. There are no bubbles between rows of any N.
- Both banks full: `in_ready`=0. It returns to 1 in the cycle after an output handshake.
- Same-edge row completion and output pop (on different banks): both take effect. `out_valid` stays 1 and the next row is presented without a gap.
- `in_log2n` changing mid-row is ignored. The length latched on beat 0 governs the whole row.
- `rst` asserted mid-row or mid-stall:
  - Partial and full rows are discarded.
  - Pointers and counters return to 0.
  - Nothing partial is ever presented.
- N=4 with LANES=4: every beat is both first and last. The row completes in one beat.

## Structure
- Shared package `saus_pkg`:
  - `MAX_N`=32, `LOG2_MAX_N`=5.
  - `sample_t` (signed [WIDTH-1:0]).
  - Row vector typedef `sample_t [31:0]`.
  - `depth_of(log2n)` function and the legal log2n range constants. These are shared with the permutation stage.
- One natural sub-module, `saus_row_bank`: a single 32-entry bank with clear-on-first-beat, lane write at an offset, and full/log2n state. It is instantiated twice; the top holds the pointers, beat counter and handshakes.

## Test plan
- N=32, LANES=4: 8 back-to-back beats of samples 0..31, `out_ready`=1.
  - Required: `out_valid` one cycle after beat 8.
  - `out_vector[i]`=i, `out_depth`=0.
- N=8 (log2n=3): beats {-1,-2,-3,-4} then {5,6,7,8}.
  - Required: positions 0..7 = -1,-2,-3,-4,5,6,7,8.
  - Positions 8..31 = 0, `out_depth`=2.
- Stalls: `out_ready`=0, stream three N=4 rows.
  - Rows 1 and 2 are accepted; `in_ready` drops after row 2 completes.
  - Raise `out_ready` for one cycle: row 1 pops, row 2 is presented, and `in_ready`=1 in the next cycle.
- Mixed sizes: an N=4 row then an N=16 row, continuous.
  - Required: no idle input cycle.
  - Outputs in order with `out_depth` 3 then 1.
- Illegal size: `in_log2n`=7 on beat 0.
  - Required: `err_size` pulses once.
  - The row completes after 8 beats with `out_depth`=0.
- `rst` pulsed after 3 beats of an N=32 row.
  - Required: no output.
  - The next full N=32 row is presented correctly, with no stale samples.
